native_burst_splitter: RTL
==========================

NATIVE_BURST_SPLITTER -- requirements
Module: native_burst_splitter

Interface
REQ-001 The block SHALL take parameter ADDR_W, default 32: byte address width.
REQ-002 The block SHALL take parameter LEN_W, default 8: request length field width, in bursts minus one.
REQ-003 The block SHALL take parameter BURST_BYTES, default 32: bytes per LPDDR4 BL16 x16 burst; a power of two.
REQ-004 Port clk, input, 1: the single clock; all logic is on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port enable, input, 1: high permits acceptance of new native requests.
REQ-007 Port req_valid_i, input, 1: a native request is presented by the native2protocol stage.
REQ-008 Port req_ready_o, output, 1: the splitter accepts the request this cycle.
REQ-009 Port req_we_i, input, 1: 1 = write, 0 = read.
REQ-010 Port req_addr_i, input, ADDR_W: start byte address, BURST_BYTES aligned.
REQ-011 Port req_len_i, input, LEN_W: number of bursts minus one.
REQ-012 Port prot_valid_o, output, 1: a burst command is presented to the protocol layer.
REQ-013 Port prot_ready_i, input, 1: the protocol layer accepts the burst command.
REQ-014 Port prot_we_o, output, 1: write flag of the current burst.
REQ-015 Port prot_addr_o, output, ADDR_W: byte address of the current burst.
REQ-016 Port prot_seq_o, output, LEN_W: index of the burst within its request, starting at 0.
REQ-017 Port prot_last_o, output, 1: the current burst is the final burst of its request.
REQ-018 Port busy_o, output, 1: a request is held and being split.

Function
REQ-019 The block SHALL implement a two-state FSM with states IDLE and SPLIT.
REQ-020 In IDLE, req_ready_o SHALL equal enable; in SPLIT, req_ready_o SHALL be 0.
REQ-021 A request SHALL be accepted when req_valid_i and req_ready_o are both 1; on acceptance the block latches we, addr and len, clears seq to 0, and enters SPLIT on the next edge.
REQ-022 In SPLIT, prot_valid_o SHALL be 1 and busy_o SHALL be 1; in IDLE, both SHALL be 0.
REQ-023 prot_we_o, prot_addr_o, prot_seq_o and prot_last_o SHALL be register outputs, held stable while prot_valid_o=1 and prot_ready_i=0.
REQ-024 prot_last_o SHALL be 1 exactly when prot_seq_o equals the latched len.
REQ-025 On a handshake with prot_last_o=0, the block SHALL add BURST_BYTES to prot_addr_o and add 1 to prot_seq_o on the next edge, giving one burst per cycle under continuous ready.
REQ-026 prot_addr_o SHALL wrap modulo 2^ADDR_W, with no error and no stall.
REQ-027 On a handshake with prot_last_o=1, the FSM SHALL return to IDLE; at least one idle cycle (prot_valid_o=0) therefore separates consecutive requests.
REQ-028 Request latency SHALL be exactly 1 cycle: the first burst is valid on the cycle after acceptance.
REQ-029 req_len_i=0 SHALL produce one burst with prot_seq_o=0 and prot_last_o=1.
REQ-030 req_len_i=all-ones SHALL produce 2^LEN_W bursts, with no seq overflow.
REQ-031 Deasserting enable during SPLIT SHALL NOT abort the request; the request completes and no new request is accepted until enable=1.
REQ-032 req_valid_i while in SPLIT SHALL be ignored; the request is not latched and must be held by the upstream stage.
REQ-033 Address bits below log2(BURST_BYTES) SHALL be forced to 0 on capture.

Reset
REQ-034 With rst_n=0, the FSM SHALL be in IDLE asynchronously and all registers SHALL be 0: prot_valid_o=0, prot_we_o=0, prot_addr_o=0, prot_seq_o=0, busy_o=0.
REQ-035 req_ready_o SHALL be 0 while rst_n=0.
REQ-036 Reset asserted during SPLIT SHALL discard the remaining bursts; no burst is emitted after reset releases until a new request is accepted.
REQ-037 Reset release SHALL take effect on the first rising clk edge after rst_n rises.

Verification
REQ-038 Scenario, single burst: enable=1, read, addr 0x100, len 0, prot_ready_i=1 -> one cycle with prot_valid_o=1, addr 0x100, seq 0, last=1, we=0; IDLE on the next cycle.
REQ-039 Scenario, multi-burst with backpressure: write, addr 0x1000, len 3; prot_ready_i low for 2 cycles on the second burst -> addrs 0x1000/0x1020/0x1040/0x1060, seq 0..3, last only on 0x1060, outputs held during the stall.
REQ-040 Scenario, wrap: addr 0xFFFFFFE0, len 1 -> addrs 0xFFFFFFE0 then 0x00000000, last on the second burst.
REQ-041 Scenario, enable drop: enable falls on the second burst of a len-2 request -> all 3 bursts emitted; a following req_valid_i is not accepted until enable returns to 1.
REQ-042 Scenario, reset mid-request: rst_n pulsed low during the 3rd burst of a len-7 request -> prot_valid_o=0 immediately; after release, req_ready_o=1 with no stray bursts.
REQ-043 Scenario, maximum length: len 0xFF, prot_ready_i=1 -> 256 consecutive bursts, seq 0..255, last on seq 255, final addr equal to start + 0x1FE0.

Source files
------------

// File: rtl/native_burst_splitter.sv
// Splits a native multi-burst request into one protocol command per BL16 burst,
// emitting incrementing addresses and a per-request sequence index.
module native_burst_splitter #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned LEN_W       = 8,
   parameter int unsigned BURST_BYTES = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [LEN_W-1:0]  req_len_i,
   output logic              prot_valid_o,
   input  logic              prot_ready_i,
   output logic              prot_we_o,
   output logic [ADDR_W-1:0] prot_addr_o,
   output logic [LEN_W-1:0]  prot_seq_o,
   output logic              prot_last_o,
   output logic              busy_o
);

   localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(BURST_BYTES - 1);
   localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(BURST_BYTES);

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_e;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  seq_q, seq_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic              last_q, last_d;
   logic              accept;

   // Ready is forced low during reset even though the state register already reads IDLE.
   assign req_ready_o = rst_n & enable & (state_q == IDLE);
   assign accept      = req_valid_i & req_ready_o;

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      addr_d  = addr_q;
      seq_d   = seq_q;
      len_d   = len_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = SPLIT;
               we_d    = req_we_i;
               addr_d  = req_addr_i & ~OFS_MASK;
               seq_d   = '0;
               len_d   = req_len_i;
               last_d  = (req_len_i == '0);
            end
         end
         SPLIT: begin
            if (prot_ready_i) begin
               if (last_q) begin
                  state_d = IDLE;
               end else begin
                  // Address wraps naturally at 2^ADDR_W.
                  addr_d = addr_q + STEP;
                  seq_d  = seq_q + LEN_W'(1);
                  last_d = ((seq_q + LEN_W'(1)) == len_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         seq_q   <= '0;
         len_q   <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         seq_q   <= seq_d;
         len_q   <= len_d;
         last_q  <= last_d;
      end
   end

   assign prot_valid_o = (state_q == SPLIT);
   assign busy_o       = (state_q == SPLIT);
   assign prot_we_o    = we_q;
   assign prot_addr_o  = addr_q;
   assign prot_seq_o   = seq_q;
   assign prot_last_o  = last_q;

endmodule
